// File: rtl/mul_share_resp.sv
// mul_share_resp: responder for the shared 53x27 unsigned multiplier.
// Two requester ports are arbitrated into one pipelined multiplier. Port 0
// wins the issue slot. Port 1 has a one-entry hold buffer, so a port-1
// request that loses the slot is kept rather than dropped. A starvation
// counter forces the buffered entry through ahead of port 0 once it has
// waited STARVE_MAX cycles. Each 80-bit product is returned to the port
// that issued it, in issue order.
//
// The product is split into two partial products at issue time
// (A*B[13:0] and A*B[26:14]). The partial products travel down the
// LAT-deep pipeline and are summed into the 80-bit result when it is
// loaded into the output register.
module mul_share_resp #(
    parameter int LAT        = 2,  // issue edge to result edge, 1..4
    parameter int STARVE_MAX = 4   // buffered wait cycles before forced issue, 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en0,
    input  logic [52:0] req0_in_1,
    input  logic [26:0] req0_in_2,
    output logic        rdy0,
    output logic [79:0] out0,
    output logic        vld0,
    input  logic        en1,
    input  logic [52:0] req1_in_1,
    input  logic [26:0] req1_in_2,
    output logic        rdy1,
    output logic [79:0] out1,
    output logic        vld1,
    output logic        busy
);

    localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

    // Port-1 hold buffer and its starvation counter
    logic        r_buf_vld;
    logic [52:0] r_buf_a;
    logic [26:0] r_buf_b;
    logic [3:0]  r_starve;

    // Issue-slot decision
    logic        w_force;
    logic        w_iss_vld;
    logic        w_iss_tag;
    logic        w_iss_from_buf;
    logic        w_iss_p1;
    logic [52:0] w_iss_a;
    logic [26:0] w_iss_b;
    logic        w_acc1;
    logic        w_buf_wr;

    // Partial products formed at issue
    logic [66:0] w_pp_lo;
    logic [65:0] w_pp_hi;

    // Multiplier pipeline
    logic [LAT-1:0] r_pv;
    logic [LAT-1:0] r_ptag;
    logic [66:0]    r_plo [LAT];
    logic [65:0]    r_phi [LAT];
    logic [79:0]    w_prod;

    // Result registers
    logic [79:0] r_out0;
    logic [79:0] r_out1;
    logic        r_vld0;
    logic        r_vld1;

    // The buffered entry is forced through once it has waited long enough.
    assign w_force = r_buf_vld && (r_starve == C_STARVE_MAX);

    // Port 1 is accepted whenever the buffer is empty, even when it loses
    // the slot; the losing request then lands in the buffer.
    assign w_acc1   = en1 && !r_buf_vld;
    assign w_buf_wr = w_acc1 && !w_iss_p1;

    assign rdy0 = !w_force;
    assign rdy1 = !r_buf_vld;

    // Priority select of the single issue slot: forced buffer, port 0, buffer, port 1
    always_comb begin
        w_iss_vld      = 1'b0;
        w_iss_tag      = 1'b0;
        w_iss_from_buf = 1'b0;
        w_iss_p1       = 1'b0;
        w_iss_a        = '0;
        w_iss_b        = '0;
        if (w_force) begin
            w_iss_vld      = 1'b1;
            w_iss_tag      = 1'b1;
            w_iss_from_buf = 1'b1;
            w_iss_a        = r_buf_a;
            w_iss_b        = r_buf_b;
        end else if (en0) begin
            w_iss_vld = 1'b1;
            w_iss_tag = 1'b0;
            w_iss_a   = req0_in_1;
            w_iss_b   = req0_in_2;
        end else if (r_buf_vld) begin
            w_iss_vld      = 1'b1;
            w_iss_tag      = 1'b1;
            w_iss_from_buf = 1'b1;
            w_iss_a        = r_buf_a;
            w_iss_b        = r_buf_b;
        end else if (en1) begin
            w_iss_vld = 1'b1;
            w_iss_tag = 1'b1;
            w_iss_p1  = 1'b1;
            w_iss_a   = req1_in_1;
            w_iss_b   = req1_in_2;
        end
    end

    // Both partial products are computed at full width so nothing is truncated.
    assign w_pp_lo = {14'd0, w_iss_a} * {53'd0, w_iss_b[13:0]};
    assign w_pp_hi = {13'd0, w_iss_a} * {53'd0, w_iss_b[26:14]};

    // Final recombination of the last stage's partial products.
    assign w_prod = {13'd0, r_plo[LAT-1]} + {r_phi[LAT-1], 14'd0};

    // Hold buffer fill/free and starvation counting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_buf_vld <= 1'b0;
            r_buf_a   <= '0;
            r_buf_b   <= '0;
            r_starve  <= '0;
        end else if (w_iss_from_buf) begin
            // rdy1 was low this cycle, so no refill can coincide with the free.
            r_buf_vld <= 1'b0;
            r_starve  <= '0;
        end else if (w_buf_wr) begin
            r_buf_vld <= 1'b1;
            r_buf_a   <= req1_in_1;
            r_buf_b   <= req1_in_2;
            r_starve  <= '0;
        end else if (r_buf_vld) begin
            if (r_starve != C_STARVE_MAX) begin
                r_starve <= r_starve + 4'd1;
            end
        end else begin
            r_starve <= '0;
        end
    end

    // Multiplier pipeline: advances every cycle, no backpressure
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pv   <= '0;
            r_ptag <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_plo[i] <= '0;
                r_phi[i] <= '0;
            end
        end else begin
            r_pv[0]   <= w_iss_vld;
            r_ptag[0] <= w_iss_tag;
            if (w_iss_vld) begin
                r_plo[0] <= w_pp_lo;
                r_phi[0] <= w_pp_hi;
            end
            for (int i = 1; i < LAT; i++) begin
                r_pv[i]   <= r_pv[i-1];
                r_ptag[i] <= r_ptag[i-1];
                r_plo[i]  <= r_plo[i-1];
                r_phi[i]  <= r_phi[i-1];
            end
        end
    end

    // Route the finished product to its port; the other port's output holds
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out0 <= '0;
            r_out1 <= '0;
            r_vld0 <= 1'b0;
            r_vld1 <= 1'b0;
        end else begin
            r_vld0 <= r_pv[LAT-1] && !r_ptag[LAT-1];
            r_vld1 <= r_pv[LAT-1] &&  r_ptag[LAT-1];
            if (r_pv[LAT-1] && !r_ptag[LAT-1]) begin
                r_out0 <= w_prod;
            end
            if (r_pv[LAT-1] && r_ptag[LAT-1]) begin
                r_out1 <= w_prod;
            end
        end
    end

    assign out0 = r_out0;
    assign out1 = r_out1;
    assign vld0 = r_vld0;
    assign vld1 = r_vld1;
    assign busy = (|r_pv) || r_buf_vld;

endmodule

// File: tb/tb_mul_share_resp.sv
// Bench for mul_share_resp. A driver process issues requests and advances a
// behavioural model of the arbitration rules, pushing each expected product
// into a per-port queue together with its due edge. A separate monitor pops
// and compares whenever the DUT pulses vld0/vld1.
module tb_mul_share_resp;

    localparam int LAT        = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en0 = 1'b0;
    logic        en1 = 1'b0;
    logic [52:0] req0_in_1 = '0;
    logic [26:0] req0_in_2 = '0;
    logic [52:0] req1_in_1 = '0;
    logic [26:0] req1_in_2 = '0;
    logic        rdy0, rdy1, vld0, vld1, busy;
    logic [79:0] out0, out1;

    mul_share_resp #(.LAT(LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .en0(en0), .req0_in_1(req0_in_1), .req0_in_2(req0_in_2),
        .rdy0(rdy0), .out0(out0), .vld0(vld0),
        .en1(en1), .req1_in_1(req1_in_1), .req1_in_2(req1_in_2),
        .rdy1(rdy1), .out1(out1), .vld1(vld1),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        bit tag;
    } fl_t;

    fl_t         flq[$];
    logic [79:0] exp0_q[$];
    logic [79:0] exp1_q[$];
    logic [79:0] last0 = '0;
    logic [79:0] last1 = '0;
    int          checks = 0;
    int          errors = 0;
    int          e = 0;
    bit          mon_en = 1'b0;
    bit          ev0, ev1;

    // model state: hold buffer and wait count in plain terms
    bit          m_buf = 1'b0;
    logic [79:0] m_buf_prod = '0;
    int          m_starve = 0;

    // requester state: a pending request is held until accepted
    bit          p0 = 1'b0, p1 = 1'b0;
    logic [52:0] a0 = '0, a1 = '0;
    logic [26:0] b0 = '0, b1 = '0;

    always @(posedge clk) e <= e + 1;

    function automatic logic [79:0] ref_mul(input logic [52:0] a, input logic [26:0] b);
        logic [79:0] x, y;
        x = {27'd0, a};
        y = {53'd0, b};
        return x * y;
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0b required=%0b t=%0t", name, act, req, $time);
        end
    endtask

    // monitor: result timing, per-port ordering and held outputs
    always @(negedge clk) begin
        if (mon_en) begin
            ev0 = 1'b0;
            ev1 = 1'b0;
            if (flq.size() > 0 && flq[0].due == e) begin
                if (flq[0].tag) ev1 = 1'b1;
                else            ev0 = 1'b1;
                void'(flq.pop_front());
            end
            chk1("vld0_timing", vld0, ev0);
            chk1("vld1_timing", vld1, ev1);
            if (vld0) begin
                if (exp0_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out0_unexpected: actual=%0h required=none", out0);
                end else begin
                    last0 = exp0_q.pop_front();
                end
            end
            if (vld1) begin
                if (exp1_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out1_unexpected: actual=%0h required=none", out1);
                end else begin
                    last1 = exp1_q.pop_front();
                end
            end
            chk("out0", out0, last0);
            chk("out1", out1, last1);
        end
    end

    // One cycle, entered at a negedge: check handshake outputs, drive inputs,
    // apply the arbitration rules to the model, then wait for the next negedge.
    task automatic cycle_step();
        bit          force_e, busy_e, acc0, acc1, iss, iss_tag, from_buf, p1_iss;
        logic [79:0] iss_prod;
        force_e = m_buf && (m_starve == STARVE_MAX);
        busy_e  = m_buf;
        foreach (flq[i]) if (flq[i].due > e) busy_e = 1'b1;
        chk1("rdy0", rdy0, !force_e);
        chk1("rdy1", rdy1, !m_buf);
        chk1("busy", busy, busy_e);

        en0 = p0; req0_in_1 = a0; req0_in_2 = b0;
        en1 = p1; req1_in_1 = a1; req1_in_2 = b1;

        acc0 = p0 && !force_e;
        acc1 = p1 && !m_buf;
        iss = 1'b0; iss_tag = 1'b0; from_buf = 1'b0; p1_iss = 1'b0; iss_prod = '0;
        if (force_e) begin
            iss = 1'b1; iss_tag = 1'b1; from_buf = 1'b1; iss_prod = m_buf_prod;
        end else if (p0) begin
            iss = 1'b1; iss_tag = 1'b0; iss_prod = ref_mul(a0, b0);
        end else if (m_buf) begin
            iss = 1'b1; iss_tag = 1'b1; from_buf = 1'b1; iss_prod = m_buf_prod;
        end else if (p1) begin
            iss = 1'b1; iss_tag = 1'b1; p1_iss = 1'b1; iss_prod = ref_mul(a1, b1);
        end
        if (iss) begin
            flq.push_back('{due: e + 1 + LAT, tag: iss_tag});
            if (iss_tag) exp1_q.push_back(iss_prod);
            else         exp0_q.push_back(iss_prod);
        end
        if (from_buf) begin
            m_buf = 1'b0;
            m_starve = 0;
        end else if (m_buf) begin
            if (m_starve < STARVE_MAX) m_starve++;
        end
        if (acc1 && !p1_iss) begin
            m_buf = 1'b1;
            m_buf_prod = ref_mul(a1, b1);
            m_starve = 0;
        end
        if (acc0) p0 = 1'b0;
        if (acc1) p1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic new_req0();
        a0 = 53'({$urandom(), $urandom()});
        b0 = 27'($urandom());
        p0 = 1'b1;
    endtask

    task automatic new_req1();
        a1 = 53'({$urandom(), $urandom()});
        b1 = 27'($urandom());
        p1 = 1'b1;
    endtask

    task automatic run(input int n, input bit w0, input bit w1);
        for (int k = 0; k < n; k++) begin
            if (w0 && !p0) new_req0();
            if (w1 && !p1) new_req1();
            cycle_step();
        end
    endtask

    // asynchronous reset applied away from the edges; discards everything in flight
    task automatic do_reset();
        #2;
        reset = 1'b0;
        flq.delete();
        exp0_q.delete();
        exp1_q.delete();
        last0 = '0; last1 = '0;
        m_buf = 1'b0; m_starve = 0;
        p0 = 1'b0; p1 = 1'b0;
        en0 = 1'b0; en1 = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((flq.size() > 0 || m_buf || p0 || p1) && n < 60) begin
            cycle_step();
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL drain_timeout: actual=%0d pending results required=0", flq.size());
        end
        run(3, 1'b0, 1'b0);
        chk1("exp0_all_returned", exp0_q.size() == 0, 1'b1);
        chk1("exp1_all_returned", exp1_q.size() == 0, 1'b1);
    endtask

    initial begin
        #1 reset = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);

        // single port-0 request 3*5
        a0 = 53'd3; b0 = 27'd5; p0 = 1'b1;
        run(6, 1'b0, 1'b0);

        // maximum operands on both ports
        a0 = '1; b0 = '1; p0 = 1'b1;
        cycle_step();
        a1 = '1; b1 = '1; p1 = 1'b1;
        run(6, 1'b0, 1'b0);

        // collision: port 0 wins, port 1 buffered then issued
        a0 = 53'd2; b0 = 27'd7; p0 = 1'b1;
        a1 = 53'd4; b1 = 27'd9; p1 = 1'b1;
        run(6, 1'b0, 1'b0);

        // starvation: port 0 streams, buffered port-1 entry must be forced out
        new_req1();
        run(14, 1'b1, 1'b0);
        drain();

        // streaming: alternate ports every cycle
        for (int k = 0; k < 64; k++) run(1, (k % 2) == 0, (k % 2) == 1);
        drain();

        // random traffic
        for (int k = 0; k < 150; k++)
            run(1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
        drain();

        // reset with two stages valid and the buffer full
        new_req0(); new_req1();
        cycle_step();
        new_req0();
        cycle_step();
        do_reset();
        new_req0();
        run(6, 1'b0, 1'b0);
        new_req1();
        run(6, 1'b0, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
